// File: rtl/ps2_direction_decoder_pkg.sv
// Shared types and constants for the PS/2 direction decoder: frame states,
// scan codes and the direction lookup used by the decode stage.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] SC_E_UP    = 8'h75;
    localparam logic [7:0] SC_E_DOWN  = 8'h72;
    localparam logic [7:0] SC_E_LEFT  = 8'h6B;
    localparam logic [7:0] SC_E_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP      = 8'h1D;
    localparam logic [7:0] SC_DOWN    = 8'h1B;
    localparam logic [7:0] SC_LEFT    = 8'h1C;
    localparam logic [7:0] SC_RIGHT   = 8'h23;

    localparam int DEF_FILTER_LEN  = 8;
    localparam int DEF_TIMEOUT_CYC = 50000;
    localparam int DEF_CNT_W       = 16;

    // One-hot {up, down, left, right}; all zero for any unmatched byte.
    function automatic logic [3:0] dir_match(input logic ext, input logic [7:0] code);
        logic [3:0] hit;
        hit = 4'b0000;
        if (ext) begin
            case (code)
                SC_E_UP:    hit = 4'b1000;
                SC_E_DOWN:  hit = 4'b0100;
                SC_E_LEFT:  hit = 4'b0010;
                SC_E_RIGHT: hit = 4'b0001;
                default:    hit = 4'b0000;
            endcase
        end else begin
            case (code)
                SC_UP:      hit = 4'b1000;
                SC_DOWN:    hit = 4'b0100;
                SC_LEFT:    hit = 4'b0010;
                SC_RIGHT:   hit = 4'b0001;
                default:    hit = 4'b0000;
            endcase
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_direction_decoder_rx_frame.sv
// PS/2 receive front end: line synchronisers, ps2_clk glitch filter and the
// 11-bit frame FSM with a mid-frame idle timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);

    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_filt, r_filt_d;
    logic [FW-1:0]   r_filt_cnt;
    logic [CNT_W-1:0] r_to_cnt;

    frame_state_t    r_state, w_state_nx;
    logic [2:0]      r_bit_cnt, w_bit_cnt_nx;
    logic [7:0]      r_shift, w_shift_nx;
    logic            r_par, w_par_nx;
    logic [7:0]      r_byte, w_byte_nx;
    logic            r_valid, w_valid_nx;
    logic            r_err, w_err_nx;

    logic            w_strobe, w_bit, w_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_filt_d <= r_filt;
            // Any sample agreeing with the filtered level restarts the run.
            if (r_clk_s2 == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt     <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_strobe  = r_filt_d & ~r_filt;
    assign w_bit     = r_dat_s2;
    assign w_timeout = (r_state != IDLE) && !w_strobe &&
                       (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (w_strobe || r_state == IDLE) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_byte    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_shift   <= w_shift_nx;
            r_par     <= w_par_nx;
            r_byte    <= w_byte_nx;
            r_valid   <= w_valid_nx;
            r_err     <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_bit_cnt_nx = r_bit_cnt;
        w_shift_nx   = r_shift;
        w_par_nx     = r_par;
        w_byte_nx    = r_byte;
        w_valid_nx   = 1'b0;
        w_err_nx     = 1'b0;
        if (w_timeout) begin
            w_state_nx = IDLE;
            w_err_nx   = 1'b1;
        end else if (w_strobe) begin
            case (r_state)
                IDLE: begin
                    if (!w_bit) begin
                        w_state_nx   = DATA;
                        w_bit_cnt_nx = '0;
                    end
                end
                DATA: begin
                    w_shift_nx   = {w_bit, r_shift[7:1]};
                    w_bit_cnt_nx = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_state_nx = PARITY;
                end
                PARITY: begin
                    w_par_nx   = w_bit;
                    w_state_nx = STOP;
                end
                STOP: begin
                    if (w_bit && (^{r_shift, r_par})) begin
                        w_byte_nx  = r_shift;
                        w_valid_nx = 1'b1;
                    end else begin
                        w_err_nx   = 1'b1;
                    end
                    w_state_nx = IDLE;
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_valid;
    assign o_frame_err  = r_err;

endmodule

// File: rtl/ps2_direction_decoder.sv
// Keyboard-to-sprite direction decoder: receives PS/2 frames and holds
// up/down/left/right levels from arrow and WASD make/break codes.
module ps2_direction_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic [7:0] oScan_code,
    output logic       oScan_valid,
    output logic       oFrame_err
);

    logic       r_rst_meta, r_rst_sync;
    logic       r_ext, r_brk;
    logic [3:0] r_dir;
    logic [7:0] w_byte;
    logic       w_valid, w_err;
    logic [3:0] w_hit;

    // Reset asserts immediately but releases in step with iVGA_CLK.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_rx (
        .i_clk        (iVGA_CLK),
        .i_rst_n      (r_rst_sync),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte       (w_byte),
        .o_byte_valid (w_valid),
        .o_frame_err  (w_err)
    );

    assign w_hit = dir_match(r_ext, w_byte);

    always_ff @(posedge iVGA_CLK or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
            r_dir <= 4'b0000;
        end else if (w_err) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (w_valid) begin
            if (w_byte == SC_EXT) begin
                r_ext <= 1'b1;
            end else if (w_byte == SC_BRK) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
                r_dir <= (r_dir & ~w_hit) | (w_hit & {4{~r_brk}});
            end
        end
    end

    assign {up, down, left, right} = r_dir;
    assign oScan_code  = w_byte;
    assign oScan_valid = w_valid;
    assign oFrame_err  = w_err;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Self-checking bench for ps2_direction_decoder: directed scenarios plus a
// randomized byte stream checked against a table-driven keyboard model.
module tb_ps2_direction_decoder;

    localparam int TO = 3000;
    localparam int H  = 40;
    localparam logic [7:0] ARROW[4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    localparam logic [7:0] WASD[4]  = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    localparam logic [7:0] MISC[3]  = '{8'hE1, 8'hAA, 8'hFA};

    logic       clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic       up, down, left, right, valid, ferr;
    logic [7:0] code;
    wire  [3:0] dirs = {up, down, left, right};

    int         n_chk = 0, n_pass = 0;
    logic [7:0] q_got[$];
    int         err_seen = 0;
    logic [3:0] dir_at = 4'b0, dir_after = 4'b0;
    bit         pend = 1'b0;

    bit         m_ext = 1'b0, m_brk = 1'b0;
    logic [3:0] m_dir = 4'b0;

    ps2_direction_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .iVGA_CLK (clk), .iRST_n (rst_n), .ps2_clk (ps2_clk), .ps2_data (ps2_data),
        .up (up), .down (down), .left (left), .right (right),
        .oScan_code (code), .oScan_valid (valid), .oFrame_err (ferr)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (pend) begin
            dir_after = dirs;
            pend = 1'b0;
        end
        if (valid) begin
            q_got.push_back(code);
            dir_at = dirs;
            pend = 1'b1;
        end
        if (ferr) err_seen++;
    end

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            for (int i = 0; i < 4; i++)
                if ((m_ext ? ARROW[i] : WASD[i]) == b) m_dir[3-i] = ~m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic void model_err();
        m_ext = 1'b0;
        m_brk = 1'b0;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic ps2_bit(input bit b);
        ps2_data = b;
        wait_cyc(H / 2);
        ps2_clk = 1'b0;
        wait_cyc(H);
        ps2_clk = 1'b1;
        wait_cyc(H / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        bit p;
        p = (~^b) ^ bad;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(1'b1);
        wait_cyc(20);
        if (bad) model_err();
        else model_byte(b);
    endtask

    task automatic clear_mon();
        q_got.delete();
        err_seen = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cyc(5);
        #1;
        n_chk++; if ({dirs, code, valid, ferr} !== 14'b0) $display("FAIL reset_outputs got=%h expected=0", {dirs, code, valid, ferr}); else n_pass++;
        rst_n = 1'b1;
        wait_cyc(30);
        n_chk++; if (dirs !== 4'b0 || q_got.size() != 0 || err_seen != 0) $display("FAIL reset_release dirs=%b codes=%0d errs=%0d expected 0", dirs, q_got.size(), err_seen); else n_pass++;
    endtask

    task automatic test_basic();
        clear_mon();
        send_frame(8'hE0, 0);
        send_frame(8'h75, 0);
        n_chk++; if (q_got.size() != 2 || q_got[0] !== 8'hE0 || q_got[1] !== 8'h75) $display("FAIL basic_codes got n=%0d %h %h expected E0 75", q_got.size(), q_got[0], q_got[1]); else n_pass++;
        n_chk++; if (dir_at !== 4'b0000 || dir_after !== 4'b1000) $display("FAIL basic_timing at_valid=%b after=%b expected 0000 1000", dir_at, dir_after); else n_pass++;
        n_chk++; if (dirs !== 4'b1000 || err_seen != 0) $display("FAIL basic_up dirs=%b errs=%0d expected 1000 0", dirs, err_seen); else n_pass++;
    endtask

    task automatic test_release();
        clear_mon();
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
        n_chk++; if (dirs !== 4'b0000 || q_got.size() != 3) $display("FAIL release_up dirs=%b codes=%0d expected 0000 3", dirs, q_got.size()); else n_pass++;
        send_frame(8'h1C, 0);
        n_chk++; if (dirs !== 4'b0010) $display("FAIL make_a dirs=%b expected 0010", dirs); else n_pass++;
        send_frame(8'hF0, 0); send_frame(8'h1C, 0);
        n_chk++; if (dirs !== 4'b0000 || err_seen != 0) $display("FAIL break_a dirs=%b errs=%0d expected 0000 0", dirs, err_seen); else n_pass++;
    endtask

    task automatic test_parity();
        clear_mon();
        send_frame(8'h75, 1);
        n_chk++; if (err_seen != 1 || q_got.size() != 0 || dirs !== 4'b0000) $display("FAIL parity_err errs=%0d codes=%0d dirs=%b expected 1 0 0000", err_seen, q_got.size(), dirs); else n_pass++;
        clear_mon();
        send_frame(8'h1D, 0);
        n_chk++; if (dirs !== 4'b1000 || q_got.size() != 1 || q_got[0] !== 8'h1D) $display("FAIL after_parity dirs=%b code=%h expected 1000 1D", dirs, q_got[0]); else n_pass++;
    endtask

    task automatic test_timeout();
        int n;
        clear_mon();
        ps2_bit(1'b0);
        ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        n = 0;
        while (err_seen == 0 && n < 2 * TO) begin
            @(posedge clk);
            n++;
        end
        model_err();
        n_chk++; if (n < TO - 80 || n > TO - 20) $display("FAIL timeout_latency got=%0d cycles expected %0d..%0d", n, TO - 80, TO - 20); else n_pass++;
        wait_cyc(200);
        n_chk++; if (err_seen != 1 || q_got.size() != 0) $display("FAIL timeout_pulse errs=%0d codes=%0d expected 1 0", err_seen, q_got.size()); else n_pass++;
        clear_mon();
        send_frame(8'h23, 0);
        n_chk++; if (dirs !== 4'b1001 || q_got.size() != 1 || q_got[0] !== 8'h23) $display("FAIL after_timeout dirs=%b code=%h expected 1001 23", dirs, q_got[0]); else n_pass++;
    endtask

    task automatic test_glitch();
        clear_mon();
        ps2_data = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ps2_clk = 1'b0; wait_cyc(3);
            ps2_clk = 1'b1; wait_cyc(20);
        end
        ps2_data = 1'b1;
        wait_cyc(300);
        n_chk++; if (err_seen != 0 || q_got.size() != 0) $display("FAIL glitch_quiet errs=%0d codes=%0d expected 0 0", err_seen, q_got.size()); else n_pass++;
        send_frame(8'hFA, 0);
        n_chk++; if (q_got.size() != 1 || q_got[0] !== 8'hFA || dirs !== 4'b1001 || err_seen != 0) $display("FAIL after_glitch code=%h dirs=%b errs=%0d expected FA 1001 0", q_got[0], dirs, err_seen); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit bad;
        int r;
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 11);
            if (r <= 2) b = 8'hE0;
            else if (r <= 4) b = 8'hF0;
            else if (r <= 8) begin
                r = $urandom_range(0, 7);
                b = (r < 4) ? ARROW[r] : WASD[r-4];
            end else if (r == 9) b = MISC[$urandom_range(0, 2)];
            else b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            clear_mon();
            send_frame(b, bad);
            n_chk++; if (bad ? (err_seen != 1 || q_got.size() != 0) : (err_seen != 0 || q_got.size() != 1 || q_got[0] !== b)) $display("FAIL rand_frame k=%0d byte=%h bad=%0d got errs=%0d codes=%0d code=%h", k, b, bad, err_seen, q_got.size(), q_got[0]); else n_pass++;
            n_chk++; if (dirs !== m_dir) $display("FAIL rand_dirs k=%0d byte=%h got=%b expected=%b", k, b, dirs, m_dir); else n_pass++;
        end
    endtask

    task automatic test_midframe_reset();
        send_frame(8'h1D, 0);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b0);
        rst_n = 1'b0;
        #1;
        n_chk++; if (dirs !== 4'b0 || code !== 8'h00 || valid !== 1'b0 || ferr !== 1'b0) $display("FAIL midreset_outputs dirs=%b code=%h expected 0000 00", dirs, code); else n_pass++;
        wait_cyc(10);
        m_dir = 4'b0; m_ext = 1'b0; m_brk = 1'b0;
        clear_mon();
        rst_n = 1'b1;
        wait_cyc(100);
        n_chk++; if (err_seen != 0 || q_got.size() != 0) $display("FAIL midreset_quiet errs=%0d codes=%0d expected 0 0", err_seen, q_got.size()); else n_pass++;
        send_frame(8'hE0, 0);
        send_frame(8'h74, 0);
        n_chk++; if (q_got.size() != 2 || q_got[0] !== 8'hE0 || q_got[1] !== 8'h74 || dirs !== 4'b0001 || err_seen != 0) $display("FAIL midreset_fresh n=%0d %h %h dirs=%b expected E0 74 0001", q_got.size(), q_got[0], q_got[1], dirs); else n_pass++;
    endtask

    initial begin
        #6000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_release();
        test_parity();
        test_timeout();
        test_glitch();
        test_random();
        test_midframe_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
